// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Hardwired fetch/decode sequencer driving the CPU datapath
//               control pins as Moore outputs of the state and IR fields.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        mem_rdy,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        PCout,
    output logic        MDRout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  opcode,
    output logic        run
);

    localparam logic [4:0] c_OP_LD   = 5'b00000;
    localparam logic [4:0] c_OP_LDI  = 5'b00001;
    localparam logic [4:0] c_OP_ST   = 5'b00010;
    localparam logic [4:0] c_OP_ADD  = 5'b00011;
    localparam logic [4:0] c_OP_AND  = 5'b00101;
    localparam logic [4:0] c_OP_OR   = 5'b00110;
    localparam logic [4:0] c_OP_ROL  = 5'b01010;
    localparam logic [4:0] c_OP_ADDI = 5'b01011;
    localparam logic [4:0] c_OP_ANDI = 5'b01100;
    localparam logic [4:0] c_OP_ORI  = 5'b01101;
    localparam logic [4:0] c_OP_MUL  = 5'b01110;
    localparam logic [4:0] c_OP_DIV  = 5'b01111;
    localparam logic [4:0] c_OP_MFHI = 5'b10100;
    localparam logic [4:0] c_OP_MFLO = 5'b10101;
    localparam logic [4:0] c_OP_HALT = 5'b11001;

    typedef enum logic [3:0] {
        ST_RESET = 4'd0,
        ST_F0    = 4'd1,
        ST_F1    = 4'd2,
        ST_F2    = 4'd3,
        ST_T3    = 4'd4,
        ST_T4    = 4'd5,
        ST_T5    = 4'd6,
        ST_T6    = 4'd7,
        ST_T7    = 4'd8,
        ST_HALT  = 4'd9
    } state_t;

    state_t r_state;
    logic   r_f1_wait;

    logic [4:0]  w_op;
    logic [15:0] w_ra_hot;
    logic [15:0] w_rb_hot;
    logic [15:0] w_rc_hot;
    logic        w_is_alu;
    logic        w_is_imm;
    logic        w_is_ldi;
    logic        w_is_ld;
    logic        w_is_st;
    logic        w_is_muldiv;
    logic        w_is_mfhi;
    logic        w_is_mflo;
    logic        w_is_halt;
    logic [4:0]  w_imm_opcode;
    logic        w_unused_const;

    assign w_op     = ir[31:27];
    assign w_ra_hot = 16'd1 << ir[26:23];
    assign w_rb_hot = 16'd1 << ir[22:19];
    assign w_rc_hot = 16'd1 << ir[18:15];

    // The immediate field is consumed by the datapath through Cout only.
    assign w_unused_const = ^ir[14:0];

    assign w_is_alu    = (w_op >= c_OP_ADD) && (w_op <= c_OP_ROL);
    assign w_is_imm    = (w_op >= c_OP_ADDI) && (w_op <= c_OP_ORI);
    assign w_is_ldi    = (w_op == c_OP_LDI);
    assign w_is_ld     = (w_op == c_OP_LD);
    assign w_is_st     = (w_op == c_OP_ST);
    assign w_is_muldiv = (w_op == c_OP_MUL) || (w_op == c_OP_DIV);
    assign w_is_mfhi   = (w_op == c_OP_MFHI);
    assign w_is_mflo   = (w_op == c_OP_MFLO);
    assign w_is_halt   = (w_op == c_OP_HALT);

    always_comb begin
        w_imm_opcode = c_OP_ADD;
        case (w_op)
            c_OP_ANDI: w_imm_opcode = c_OP_AND;
            c_OP_ORI:  w_imm_opcode = c_OP_OR;
            default:   w_imm_opcode = c_OP_ADD;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state   <= ST_RESET;
            r_f1_wait <= 1'b0;
        end else begin
            // Marks F1 cycles after the first, so PC is loaded exactly once.
            r_f1_wait <= (r_state == ST_F1) && !mem_rdy;
            case (r_state)
                ST_RESET: r_state <= ST_F0;
                ST_F0:    r_state <= ST_F1;
                ST_F1:    r_state <= mem_rdy ? ST_F2 : ST_F1;
                ST_F2:    r_state <= ST_T3;
                ST_T3: begin
                    if (w_is_halt)
                        r_state <= ST_HALT;
                    else if (w_is_alu || w_is_imm || w_is_ldi || w_is_ld ||
                             w_is_st || w_is_muldiv)
                        r_state <= ST_T4;
                    else
                        r_state <= ST_F0;
                end
                ST_T4:    r_state <= ST_T5;
                ST_T5:    r_state <= (w_is_ld || w_is_st || w_is_muldiv) ? ST_T6 : ST_F0;
                ST_T6: begin
                    if (w_is_ld)
                        r_state <= mem_rdy ? ST_T7 : ST_T6;
                    else if (w_is_st)
                        r_state <= ST_T7;
                    else
                        r_state <= ST_F0;
                end
                ST_T7: begin
                    if (w_is_st)
                        r_state <= mem_rdy ? ST_F0 : ST_T7;
                    else
                        r_state <= ST_F0;
                end
                ST_HALT:  r_state <= ST_HALT;
                default:  r_state <= ST_RESET;
            endcase
        end
    end

    always_comb begin
        Rin      = '0;
        Rout     = '0;
        PCin     = 1'b0;
        IRin     = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        PCout    = 1'b0;
        MDRout   = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        HIout    = 1'b0;
        LOout    = 1'b0;
        Cout     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Write    = 1'b0;
        opcode   = 5'b00000;
        run      = (r_state != ST_HALT);
        case (r_state)
            ST_F0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            ST_F1: begin
                Zlowout = 1'b1;
                PCin    = !r_f1_wait;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            ST_F2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                if (w_is_muldiv) begin
                    Rout = w_ra_hot;
                    Yin  = 1'b1;
                end else if (w_is_alu || w_is_imm || w_is_ldi || w_is_ld || w_is_st) begin
                    Rout = w_rb_hot;
                    Yin  = 1'b1;
                end else if (w_is_mfhi) begin
                    HIout = 1'b1;
                    Rin   = w_ra_hot;
                end else if (w_is_mflo) begin
                    LOout = 1'b1;
                    Rin   = w_ra_hot;
                end
            end
            ST_T4: begin
                Zin = 1'b1;
                if (w_is_alu) begin
                    Rout   = w_rc_hot;
                    opcode = w_op;
                end else if (w_is_muldiv) begin
                    Rout   = w_rb_hot;
                    opcode = w_op;
                end else if (w_is_imm) begin
                    Cout   = 1'b1;
                    opcode = w_imm_opcode;
                end else begin
                    Cout   = 1'b1;
                    opcode = c_OP_ADD;
                end
            end
            ST_T5: begin
                Zlowout = 1'b1;
                if (w_is_ld || w_is_st)
                    MARin = 1'b1;
                else if (w_is_muldiv)
                    LOin = 1'b1;
                else
                    Rin = w_ra_hot;
            end
            ST_T6: begin
                if (w_is_ld) begin
                    Read  = 1'b1;
                    MDRin = 1'b1;
                end else if (w_is_st) begin
                    Rout  = w_ra_hot;
                    MDRin = 1'b1;
                end else begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            ST_T7: begin
                if (w_is_st) begin
                    Write = 1'b1;
                end else begin
                    MDRout = 1'b1;
                    Rin    = w_ra_hot;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Directed self-checking bench for control_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] ir    = '0;
    logic        mem_rdy = 1'b0;
    logic [15:0] Rin, Rout;
    logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
    logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout;
    logic        IncPC, Read, Write, run;
    logic [4:0]  opcode;

    int n_checks = 0;
    int n_errors = 0;

    // Strobe field bit positions, run in bit 0.
    localparam logic [18:0] c_RUN     = 19'd1 << 0;
    localparam logic [18:0] c_WRITE   = 19'd1 << 1;
    localparam logic [18:0] c_READ    = 19'd1 << 2;
    localparam logic [18:0] c_INCPC   = 19'd1 << 3;
    localparam logic [18:0] c_COUT    = 19'd1 << 4;
    localparam logic [18:0] c_LOOUT   = 19'd1 << 5;
    localparam logic [18:0] c_HIOUT   = 19'd1 << 6;
    localparam logic [18:0] c_ZLOOUT  = 19'd1 << 7;
    localparam logic [18:0] c_ZHIOUT  = 19'd1 << 8;
    localparam logic [18:0] c_MDROUT  = 19'd1 << 9;
    localparam logic [18:0] c_PCOUT   = 19'd1 << 10;
    localparam logic [18:0] c_LOIN    = 19'd1 << 11;
    localparam logic [18:0] c_HIIN    = 19'd1 << 12;
    localparam logic [18:0] c_ZIN     = 19'd1 << 13;
    localparam logic [18:0] c_YIN     = 19'd1 << 14;
    localparam logic [18:0] c_MDRIN   = 19'd1 << 15;
    localparam logic [18:0] c_MARIN   = 19'd1 << 16;
    localparam logic [18:0] c_IRIN    = 19'd1 << 17;
    localparam logic [18:0] c_PCIN    = 19'd1 << 18;

    logic [63:0] obs;
    assign obs = {8'h00, Rin, Rout, opcode,
                  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
                  PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout,
                  IncPC, Read, Write, run};

    control_unit dut (
        .clock(clock), .clear(clear), .ir(ir), .mem_rdy(mem_rdy),
        .Rin(Rin), .Rout(Rout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
        .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
        .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout),
        .IncPC(IncPC), .Read(Read), .Write(Write), .opcode(opcode), .run(run)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] v(input logic [15:0] rin, input logic [15:0] rout,
                                      input logic [4:0] opc, input logic [18:0] s);
        return {8'h00, rin, rout, opc, s};
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expects to be in F0; leaves the DUT in T3 with instr loaded.
    task automatic do_fetch(input logic [31:0] instr, input int waits);
        ir = instr;
        mem_rdy = 1'b1;
        check("F0", obs, v(0, 0, 0, c_PCOUT | c_MARIN | c_INCPC | c_ZIN | c_RUN));
        step();
        for (int i = 0; i <= waits; i++) begin
            mem_rdy = (i == waits);
            check("F1", obs, v(0, 0, 0, ((i == 0) ? c_PCIN : 19'd0) |
                                         c_ZLOOUT | c_READ | c_MDRIN | c_RUN));
            step();
        end
        mem_rdy = 1'b0;
        check("F2", obs, v(0, 0, 0, c_MDROUT | c_IRIN | c_RUN));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held for three cycles
        #1;
        check("reset", obs, v(0, 0, 0, c_RUN));
        repeat (3) step();
        check("reset_hold", obs, v(0, 0, 0, c_RUN));
        clear = 1'b1;
        step();

        // add r1 = r2 + r3
        do_fetch(32'h18918000, 0);
        check("add_T3", obs, v(0, 16'h0004, 0, c_YIN | c_RUN));
        step();
        check("add_T4", obs, v(0, 16'h0008, 5'b00011, c_ZIN | c_RUN));
        step();
        check("add_T5", obs, v(16'h0002, 0, 0, c_ZLOOUT | c_RUN));
        step();

        // ld r7, 5(r0) with a two-cycle fetch wait and three-cycle T6 wait
        do_fetch({5'b00000, 4'd7, 4'd0, 19'd5}, 2);
        check("ld_T3", obs, v(0, 16'h0001, 0, c_YIN | c_RUN));
        step();
        check("ld_T4", obs, v(0, 0, 5'b00011, c_COUT | c_ZIN | c_RUN));
        step();
        check("ld_T5", obs, v(0, 0, 0, c_ZLOOUT | c_MARIN | c_RUN));
        step();
        for (int i = 0; i < 4; i++) begin
            mem_rdy = (i == 3);
            check("ld_T6", obs, v(0, 0, 0, c_READ | c_MDRIN | c_RUN));
            step();
        end
        mem_rdy = 1'b1;
        check("ld_T7", obs, v(16'h0080, 0, 0, c_MDROUT | c_RUN));
        step();

        // mul r4, r5
        do_fetch({5'b01110, 4'd4, 4'd5, 19'd0}, 0);
        check("mul_T3", obs, v(0, 16'h0010, 0, c_YIN | c_RUN));
        step();
        check("mul_T4", obs, v(0, 16'h0020, 5'b01110, c_ZIN | c_RUN));
        step();
        check("mul_T5", obs, v(0, 0, 0, c_ZLOOUT | c_LOIN | c_RUN));
        step();
        check("mul_T6", obs, v(0, 0, 0, c_ZHIOUT | c_HIIN | c_RUN));
        step();

        // st r3, C(r1) with one write wait
        do_fetch({5'b00010, 4'd3, 4'd1, 19'd9}, 0);
        check("st_T3", obs, v(0, 16'h0002, 0, c_YIN | c_RUN));
        step();
        check("st_T4", obs, v(0, 0, 5'b00011, c_COUT | c_ZIN | c_RUN));
        step();
        mem_rdy = 1'b1;
        check("st_T5", obs, v(0, 0, 0, c_ZLOOUT | c_MARIN | c_RUN));
        step();
        check("st_T6", obs, v(0, 16'h0008, 0, c_MDRIN | c_RUN));
        step();
        mem_rdy = 1'b0;
        check("st_T7a", obs, v(0, 0, 0, c_WRITE | c_RUN));
        step();
        mem_rdy = 1'b1;
        check("st_T7b", obs, v(0, 0, 0, c_WRITE | c_RUN));
        step();

        // ori r6, r2, C
        do_fetch({5'b01101, 4'd6, 4'd2, 19'h00ff}, 0);
        check("ori_T3", obs, v(0, 16'h0004, 0, c_YIN | c_RUN));
        step();
        check("ori_T4", obs, v(0, 0, 5'b00110, c_COUT | c_ZIN | c_RUN));
        step();
        check("ori_T5", obs, v(16'h0040, 0, 0, c_ZLOOUT | c_RUN));
        step();

        // mfhi r9
        do_fetch({5'b10100, 4'd9, 23'd0}, 0);
        check("mfhi_T3", obs, v(16'h0200, 0, 0, c_HIOUT | c_RUN));
        step();

        // illegal opcode runs as nop
        do_fetch({5'b11111, 4'd5, 4'd6, 19'd0}, 0);
        check("ill_T3", obs, v(0, 0, 0, c_RUN));
        step();

        // halt is absorbing
        do_fetch({5'b11001, 27'd0}, 0);
        check("halt_T3", obs, v(0, 0, 0, c_RUN));
        step();
        for (int i = 0; i < 10; i++) begin
            mem_rdy = i[0];
            check("halted", obs, v(0, 0, 0, 19'd0));
            step();
        end
        clear = 1'b0;
        #1;
        check("halt_clear", obs, v(0, 0, 0, c_RUN));
        step();
        clear = 1'b1;
        step();

        // clear asynchronously in the middle of an F1 wait
        mem_rdy = 1'b0;
        check("clr_F0", obs, v(0, 0, 0, c_PCOUT | c_MARIN | c_INCPC | c_ZIN | c_RUN));
        step();
        check("clr_F1a", obs, v(0, 0, 0, c_PCIN | c_ZLOOUT | c_READ | c_MDRIN | c_RUN));
        step();
        check("clr_F1b", obs, v(0, 0, 0, c_ZLOOUT | c_READ | c_MDRIN | c_RUN));
        #2;
        clear = 1'b0;
        #1;
        check("clr_async", obs, v(0, 0, 0, c_RUN));
        step();
        clear = 1'b1;
        step();
        do_fetch({5'b11000, 27'd0}, 0);
        check("nop_T3", obs, v(0, 0, 0, c_RUN));
        step();
        check("nop_F0", obs, v(0, 0, 0, c_PCOUT | c_MARIN | c_INCPC | c_ZIN | c_RUN));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
